// File: rtl/fpu_request_master.sv
// rtl/fpu_request_master.sv - command/response initiator for the divide/sqrt unit with per-phase watchdog
module fpu_request_master #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W          = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [63:0]      cmd_a,
    input  logic [63:0]      cmd_b,
    output logic [1:0]       process,
    output logic [31:0]      a_s,
    output logic [31:0]      b_s,
    output logic [63:0]      a_d,
    output logic [63:0]      b_d,
    output logic             a_stb,
    output logic             b_stb,
    input  logic             a_ack,
    input  logic             b_ack,
    input  logic [31:0]      zs,
    input  logic [63:0]      zd,
    input  logic             z_stb,
    output logic             z_ack,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [63:0]      rsp_data,
    output logic [1:0]       rsp_op,
    output logic             rsp_timeout,
    output logic             fpu_hang,
    output logic [CNT_W-1:0] op_count
);
    typedef enum logic [2:0] {IDLE, SEND_A, SEND_B, WAIT_Z, RESP} state_t;

    localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT_CYCLES > 0 ? TIMEOUT_CYCLES - 1 : 0);

    state_t            state_q;
    logic [1:0]        op_q;
    logic [63:0]       a_q, b_q;
    logic [CNT_W-1:0]  wd_cnt_q, op_count_q;
    logic              cmd_ready_q, a_stb_q, b_stb_q, z_ack_q;
    logic              rsp_valid_q, rsp_timeout_q, fpu_hang_q;
    logic [63:0]       rsp_data_q;
    logic [1:0]        rsp_op_q;
    logic              phase_hs, wd_expire;

    // Handshake that would end the current phase on this edge.
    always_comb begin
        phase_hs = 1'b0;
        case (state_q)
            SEND_A:  phase_hs = a_ack;
            SEND_B:  phase_hs = b_ack;
            WAIT_Z:  phase_hs = z_stb;
            default: phase_hs = 1'b0;
        endcase
    end

    assign wd_expire = (TIMEOUT_CYCLES != 0) && (wd_cnt_q == WD_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            op_q          <= 2'd0;
            a_q           <= 64'd0;
            b_q           <= 64'd0;
            wd_cnt_q      <= '0;
            op_count_q    <= '0;
            cmd_ready_q   <= 1'b1;
            a_stb_q       <= 1'b0;
            b_stb_q       <= 1'b0;
            z_ack_q       <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_timeout_q <= 1'b0;
            fpu_hang_q    <= 1'b0;
            rsp_data_q    <= 64'd0;
            rsp_op_q      <= 2'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cmd_valid) begin
                        op_q        <= cmd_op;
                        a_q         <= cmd_a;
                        b_q         <= cmd_b;
                        cmd_ready_q <= 1'b0;
                        a_stb_q     <= 1'b1;
                        wd_cnt_q    <= '0;
                        state_q     <= SEND_A;
                    end
                end
                SEND_A, SEND_B, WAIT_Z: begin
                    if (phase_hs) begin
                        wd_cnt_q <= '0;
                        a_stb_q  <= 1'b0;
                        b_stb_q  <= 1'b0;
                        z_ack_q  <= 1'b0;
                        if (state_q == SEND_A && !op_q[0]) begin
                            state_q <= SEND_B;
                            b_stb_q <= 1'b1;
                        end else if (state_q != WAIT_Z) begin
                            state_q <= WAIT_Z;
                            z_ack_q <= 1'b1;
                        end else begin
                            state_q       <= RESP;
                            rsp_valid_q   <= 1'b1;
                            rsp_timeout_q <= 1'b0;
                            rsp_op_q      <= op_q;
                            rsp_data_q    <= op_q[1] ? zd : {32'd0, zs};
                        end
                    end else if (wd_expire) begin
                        // Hung unit: abandon the phase and report instead of stalling.
                        wd_cnt_q      <= '0;
                        a_stb_q       <= 1'b0;
                        b_stb_q       <= 1'b0;
                        z_ack_q       <= 1'b0;
                        state_q       <= RESP;
                        rsp_valid_q   <= 1'b1;
                        rsp_timeout_q <= 1'b1;
                        rsp_op_q      <= op_q;
                        rsp_data_q    <= 64'd0;
                        fpu_hang_q    <= 1'b1;
                    end else begin
                        wd_cnt_q <= wd_cnt_q + 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        state_q     <= IDLE;
                        if (!rsp_timeout_q) begin
                            op_count_q <= op_count_q + 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign process     = op_q;
    assign a_s         = a_q[31:0];
    assign b_s         = b_q[31:0];
    assign a_d         = a_q;
    assign b_d         = b_q;
    assign a_stb       = a_stb_q;
    assign b_stb       = b_stb_q;
    assign z_ack       = z_ack_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_data    = rsp_data_q;
    assign rsp_op      = rsp_op_q;
    assign rsp_timeout = rsp_timeout_q;
    assign fpu_hang    = fpu_hang_q;
    assign op_count    = op_count_q;
endmodule
